// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer of the 8-bit MIPS datapath.
// State encodings, halt opcode and default widths.
package pc_sequencer_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_WIDTH = 16;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_ILL  = 2'd3
    } seq_state_e;

    function automatic logic is_halt(
        input logic [3:0] op,
        input logic [3:0] halt_op
    );
        return op == halt_op;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/fetch bundle between the PC sequencer and the datapath.
// master = sequencer side, slave = datapath side.
interface pc_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_WIDTH = 16
);
    logic                 start;
    logic                 stall;
    logic [3:0]           opcode;
    logic [WIDTH-1:0]     next_pc;
    logic [WIDTH-1:0]     pc;
    logic [WIDTH-1:0]     pc_plus1;
    logic                 commit;
    logic                 running;
    logic                 halted;
    logic                 wrapped;
    logic [CNT_WIDTH-1:0] instr_count;

    modport master (
        input  start, stall, opcode, next_pc,
        output pc, pc_plus1, commit, running,
        output halted, wrapped, instr_count
    );

    modport slave (
        output start, stall, opcode, next_pc,
        input  pc, pc_plus1, commit, running,
        input  halted, wrapped, instr_count
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic at_max;

    assign at_max = &count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: PC register, RUN/HALT control, wrap flag
// and retired-instruction counter.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int         WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [3:0] HALT_OPCODE = OP_HALT,
    parameter int         CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.master bus
);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [WIDTH-1:0] pc_q;
    logic             wrap_q;
    logic             load;
    logic             retire;
    logic             commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // opcode is only looked at in RUN so X outside RUN cannot leak
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        retire  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!bus.stall) begin
                    retire = 1'b1;
                    if (is_halt(bus.opcode, HALT_OPCODE)) begin
                        state_d = ST_HALT;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (load) begin
            pc_q <= RESET_PC;
        end else if (commit) begin
            pc_q <= bus.next_pc;
        end
    end

    // Only a sequential step off the top counts as a wrap, not a branch to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else if (load) begin
            wrap_q <= 1'b0;
        end else if (commit && (&pc_q) && (bus.next_pc == '0)) begin
            wrap_q <= 1'b1;
        end
    end

    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load),
        .inc   (retire),
        .count (bus.instr_count)
    );

    assign bus.pc       = pc_q;
    assign bus.pc_plus1 = pc_q + WIDTH'(1);
    assign bus.commit   = commit;
    assign bus.running  = (state_q == ST_RUN);
    assign bus.halted   = (state_q == ST_HALT);
    assign bus.wrapped  = wrap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer against a
// behavioural model of the sequencer.
module tb_pc_sequencer;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    pc_sequencer_if #(.WIDTH(8), .CNT_WIDTH(16)) bus ();

    pc_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model
    bit m_run;
    bit m_halt;
    int m_pc;
    int m_cnt;
    bit m_wrap;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_halt = 0;
        m_pc   = 0;
        m_cnt  = 0;
        m_wrap = 0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".pc"}, 32'(bus.pc), 32'(m_pc));
        chk({tag, ".run"}, 32'(bus.running), 32'(m_run));
        chk({tag, ".halt"}, 32'(bus.halted), 32'(m_halt));
        chk({tag, ".wrap"}, 32'(bus.wrapped), 32'(m_wrap));
        chk({tag, ".cnt"}, 32'(bus.instr_count), 32'(m_cnt));
    endtask

    // Called just after a negedge: drive, check combinational outputs,
    // clock once, update model, check registered outputs.
    task automatic step(input bit s, input bit st,
                        input logic [3:0] op, input logic [7:0] np,
                        input string tag);
        bit exp_commit;
        bus.start   = s;
        bus.stall   = st;
        bus.opcode  = op;
        bus.next_pc = np;
        #1;
        exp_commit = m_run && !st && (op != 4'hF);
        chk({tag, ".commit"}, 32'(bus.commit), 32'(exp_commit));
        chk({tag, ".pc1"}, 32'(bus.pc_plus1), 32'((m_pc + 1) % 256));
        @(posedge clk);
        if (!m_run && s) begin
            m_run  = 1;
            m_halt = 0;
            m_pc   = 0;
            m_cnt  = 0;
            m_wrap = 0;
        end else if (m_run && !st) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (op == 4'hF) begin
                m_run  = 0;
                m_halt = 1;
            end else begin
                if (m_pc == 255 && np == 8'h00) m_wrap = 1;
                m_pc = int'(np);
            end
        end
        @(negedge clk);
        chk_regs(tag);
    endtask

    task automatic seq(input logic [3:0] op, input string tag);
        logic [7:0] np;
        np = bus.pc_plus1;
        step(0, 0, op, np, tag);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.start   = 0;
        bus.stall   = 0;
        bus.opcode  = 'x;
        bus.next_pc = 'x;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_regs("reset");
        chk("reset.commit", 32'(bus.commit), 32'(0));

        // X on opcode/next_pc while idle must be harmless
        step(0, 1, 4'hx, 8'hxx, "idle_x");

        // 1: sequential fetch of five instructions
        step(1, 0, 4'h0, 8'h00, "start1");
        for (int i = 0; i < 5; i++) seq(4'(i), "seq5");
        chk("seq5.pc", 32'(bus.pc), 32'h05);
        chk("seq5.cnt", 32'(bus.instr_count), 32'd5);

        // 2: stall at pc=03 with start held (ignored in RUN)
        step(1, 1, 4'h0, 8'h00, "restart_ign");
        step(0, 0, 4'h0, 8'h03, "br03");
        for (int i = 0; i < 3; i++) step(1, 1, 4'h1, 8'h77, "stall");
        chk("stall.pc", 32'(bus.pc), 32'h03);
        seq(4'h2, "release");
        chk("release.pc", 32'(bus.pc), 32'h04);

        // 3: halt at pc=07, stall first
        step(0, 0, 4'h0, 8'h07, "br07");
        step(0, 1, 4'hF, 8'h99, "halt_stall");
        step(0, 0, 4'hF, 8'h99, "halt");
        chk("halt.h", 32'(bus.halted), 32'd1);
        chk("halt.pc", 32'(bus.pc), 32'h07);
        step(0, 0, 4'h0, 8'h33, "halt_hold");
        step(1, 1, 4'h0, 8'h33, "halt_start");
        chk("halt_start.run", 32'(bus.running), 32'd1);
        chk("halt_start.cnt", 32'(bus.instr_count), 32'd0);

        // 4: branch to 0 from 10 does not wrap; stepping FF->00 does
        step(0, 0, 4'h0, 8'h10, "br10");
        step(0, 0, 4'h0, 8'h00, "br00");
        chk("br00.wrap", 32'(bus.wrapped), 32'd0);
        step(0, 0, 4'h0, 8'hFE, "brFE");
        seq(4'h0, "toFF");
        seq(4'h0, "to00");
        chk("to00.wrap", 32'(bus.wrapped), 32'd1);
        step(0, 0, 4'h0, 8'h20, "sticky");
        chk("sticky.wrap", 32'(bus.wrapped), 32'd1);

        // 5: asynchronous reset mid-run at pc=42
        step(0, 0, 4'h0, 8'h42, "br42");
        bus.stall  = 0;
        bus.opcode = 4'h0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_regs("async_rst");
        chk("async_rst.commit", 32'(bus.commit), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        chk_regs("post_rst");

        // randomized mix of start/stall/halt/branches
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 11) == 0) ? 4'hF : 4'($urandom_range(0, 14)),
                 ($urandom_range(0, 1) == 1) ? bus.pc_plus1 : 8'($urandom),
                 "rand");
        end

        // saturation of the retired count
        if (!m_run) step(1, 0, 4'h0, 8'h00, "sat_start");
        for (int i = 0; i < 65540; i++) begin
            step(0, 0, 4'($urandom_range(0, 14)), 8'($urandom), "sat");
        end
        chk("sat.cnt", 32'(bus.instr_count), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
